ahb_intc: RTL and testbench
===========================

Name: ahb_intc

Overview:
- AHB-Lite slave interrupt controller that sits directly downstream of the timer, UART, SPI and GPIO interrupt outputs.
- Latches up to NSRC interrupt sources into pending bits. Each source is individually enabled and individually edge- or level-triggered.
- Presents a single irq_o to the core, plus a claim/complete handshake so the core learns which source fired.
- No nesting: one interrupt is in service at a time.

Parameters:
- AWIDTH, 32, AHB address width.
- DWIDTH, 32, AHB data width.
- NSRC, 8, number of interrupt sources, 1..31. Source IDs run 1..NSRC; ID 0 means "none".

Ports:
- hclk  in  1  bus clock.
- hresetn  in  1  asynchronous active-low reset.
- hsel_i  in  1  slave select.
- hwrite_i  in  1  1=write.
- hready_i  in  1  bus ready.
- hsize_i  in  3  transfer size; only 32-bit is supported.
- hburst_i  in  3  ignored.
- htrans_i  in  2  transfer type; only NONSEQ/SEQ are valid.
- hwdata_i  in  DWIDTH  write data.
- haddr_i  in  AWIDTH  address; [4:0] is decoded.
- hreadyout_o  out  1  always 1 (zero wait).
- hresp_o  out  1  always 0 (OKAY).
- hrdata_o  out  DWIDTH  read data.
- irq_src_i  in  NSRC  raw interrupt lines; bit i is source ID i+1.
- irq_o  out  1  interrupt request to the core.

Behaviour:
- Clock and reset: single clock hclk; asynchronous active-low reset hresetn. Reset clears all registers, pending bits, synchronizers and the FSM (to IDLE). irq_o=0, hrdata_o=0, hreadyout_o=1, hresp_o=0.
- Bus:
  - The address phase is captured when hsel_i & hready_i & htrans_i[1]; address bits [4:2] and hwrite_i are latched.
  - Write data is applied on the data-phase clock edge.
  - hrdata_o is combinational from the latched address during the data phase and 0 otherwise.
- Register map:
  - 0x00 ENABLE (RW): bit i enables source i+1.
  - 0x04 PENDING (RO): pending bits. Writes are ignored.
  - 0x08 TRIG (RW): 1=rising-edge, 0=level-high.
  - 0x0C CLAIM (RW):
    - Read returns the lowest ID with pending & enable, and moves the FSM to CLAIMED with that ID. If no such ID exists, the read returns 0 with no state change.
    - A write of the in-service ID completes it.
  - 0x10 STATUS (RO): [4:0] in-service ID, [8] FSM busy.
  - Unmapped offsets read 0; writes to them are ignored.
- Pending:
  - Edge source: set on a synced 0->1 transition; cleared at claim.
  - Level source: follows the synced level. The claimed source is masked until complete.
  - If a set and a claim-clear of the same bit occur in the same cycle, the set wins (the bit stays pending).
- FSM, registered:
  - IDLE -> ACTIVE when |(pending & enable).
  - ACTIVE -> IDLE if that becomes 0 before a claim (e.g., the enable is cleared).
  - ACTIVE -> CLAIMED on a CLAIM read returning nonzero.
  - CLAIMED -> IDLE on a CLAIM write equal to the in-service ID. A write of any other value is ignored.
  - irq_o = (state==ACTIVE), registered.
  - A CLAIM read while IDLE/CLAIMED returns 0 or the next candidate respectively, without a state change; only one source is in service.
- Latency with synchronizers: source rises before edge 0; pending sets at edge 3; irq_o goes high at edge 4.
- After complete: if other sources are still pending, irq_o reasserts 2 cycles later (via IDLE->ACTIVE).

Optional Feature:
- Macro: AHB_INTC_SYNC_EN.
- Defined: each irq_src_i passes through a 2-flop synchronizer before edge/level detection (latencies as above).
- Undefined: sources are assumed to be in the hclk domain and used directly; pending sets at edge 1 and irq_o rises at edge 2.

Decomposition:
- Shared package/header ahb_intc_defs holds:
  - register offsets (INTC_ENABLE/PENDING/TRIG/CLAIM/STATUS);
  - FSM state encodings (IDLE=2'd0, ACTIVE=2'd1, CLAIMED=2'd2);
  - the ID-none constant 0.
- One natural sub-module, intc_src_cell, instantiated NSRC times. It contains the optional synchronizer, edge detect, and pending/mask logic for one source.
- The top level holds the AHB decode, the priority encoder and the FSM.

Test Plan:
- Reset: hresetn=0 mid-claim -> irq_o=0, STATUS=0, PENDING=0; all registers read 0 after release.
- Edge: ENABLE=0x1, TRIG=0x1, pulse src0 for 1 cycle -> irq_o high at edge 4; CLAIM read=1; irq_o low the next cycle; PENDING=0; write CLAIM=1 -> STATUS=0.
- Priority: ENABLE=0xFF, TRIG=0xFF, pulse src5 and src2 together -> CLAIM reads 3. After complete(3), irq_o reasserts and CLAIM reads 6.
- Level: TRIG=0, hold src1 high -> claim=2. Complete while still high -> irq_o reasserts and PENDING bit1=1. Drop src1 -> PENDING=0 and irq_o falls.
- Corner cases:
  - Wrong complete: claim 3, write CLAIM=4 -> STATUS stays 3.
  - Edge on src2 in the same cycle as its claim -> PENDING bit2 remains 1.
- Masking: pending src0 with ENABLE=0 -> irq_o=0 and CLAIM reads 0. Set ENABLE=1 -> irq_o rises 2 cycles later.

Source files
------------

// File: rtl/ahb_intc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_intc_defs : register offsets, FSM encodings and ID constants shared by  |
// |                 the ahb_intc interrupt controller.                          |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
package ahb_intc_defs;

  localparam logic [4:0] INTC_ENABLE  = 5'h00;
  localparam logic [4:0] INTC_PENDING = 5'h04;
  localparam logic [4:0] INTC_TRIG    = 5'h08;
  localparam logic [4:0] INTC_CLAIM   = 5'h0C;
  localparam logic [4:0] INTC_STATUS  = 5'h10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_CLAIMED = 2'd2;

  localparam logic [4:0] ID_NONE = 5'd0;

  // The data phase only keeps the word index of the address.
  function automatic logic [2:0] reg_idx(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_intc_src_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | intc_src_cell : per-source synchronizer, edge detect and pending/mask.      |
// |                 Optional 2-flop synchronizer under AHB_INTC_SYNC_EN.        |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module intc_src_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic i_src,
  input  logic i_trig,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pend
);

  logic w_sync;
  logic w_rise;
  logic r_lvl;
  logic r_lvl_d;
  logic r_pend;
  logic r_mask;

`ifdef AHB_INTC_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_src};
    end
  end

  assign w_sync = r_sync[1];
`else
  assign w_sync = i_src;
`endif

  assign w_rise = r_lvl & ~r_lvl_d;

  // An edge arriving on the claim cycle must survive the claim clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_pend  <= 1'b0;
      r_mask  <= 1'b0;
    end else begin
      r_lvl   <= w_sync;
      r_lvl_d <= r_lvl;
      if (i_trig) begin
        r_pend <= w_rise | (r_pend & ~i_claim);
      end else begin
        r_pend <= r_lvl;
      end
      if (i_claim) begin
        r_mask <= 1'b1;
      end else if (i_complete) begin
        r_mask <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend & (i_trig | ~r_mask);

endmodule
`default_nettype wire

// File: rtl/ahb_intc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_intc : AHB-Lite interrupt controller with claim/complete handshake.     |
// |            Feature macro AHB_INTC_SYNC_EN adds source synchronizers.        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module ahb_intc
  import ahb_intc_defs::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int NSRC   = 8
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel_i,
  input  logic              hwrite_i,
  input  logic              hready_i,
  input  logic [2:0]        hsize_i,
  input  logic [2:0]        hburst_i,
  input  logic [1:0]        htrans_i,
  input  logic [DWIDTH-1:0] hwdata_i,
  input  logic [AWIDTH-1:0] haddr_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic [DWIDTH-1:0] hrdata_o,
  input  logic [NSRC-1:0]   irq_src_i,
  output logic              irq_o
);

  localparam logic [2:0] c_idx_enable  = reg_idx(INTC_ENABLE);
  localparam logic [2:0] c_idx_pending = reg_idx(INTC_PENDING);
  localparam logic [2:0] c_idx_trig    = reg_idx(INTC_TRIG);
  localparam logic [2:0] c_idx_claim   = reg_idx(INTC_CLAIM);
  localparam logic [2:0] c_idx_status  = reg_idx(INTC_STATUS);

  logic              w_capture;
  logic              r_dphase;
  logic              r_dwrite;
  logic [2:0]        r_daddr;
  logic              w_wr;
  logic              w_rd;
  logic              w_claim_sel;
  logic              w_claim_go;
  logic              w_complete;
  logic              w_any;
  logic [NSRC-1:0]   r_enable;
  logic [NSRC-1:0]   r_trig;
  logic [NSRC-1:0]   w_pend;
  logic [NSRC-1:0]   w_act;
  logic [4:0]        w_cand;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [4:0]        r_id;
  logic [4:0]        w_id_nxt;
  logic              r_irq;
  logic [DWIDTH-1:0] w_rdata;
  logic              w_unused_ok;

  assign hreadyout_o = 1'b1;
  assign hresp_o     = 1'b0;
  assign irq_o       = r_irq;
  assign hrdata_o    = w_rdata;
  assign w_unused_ok = ^{hsize_i, hburst_i, htrans_i[0], haddr_i[AWIDTH-1:5], haddr_i[1:0]};

  assign w_capture   = hsel_i & hready_i & htrans_i[1];
  assign w_wr        = r_dphase & r_dwrite;
  assign w_rd        = r_dphase & ~r_dwrite;
  assign w_claim_sel = (r_daddr == c_idx_claim);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_dphase <= 1'b0;
      r_dwrite <= 1'b0;
      r_daddr  <= 3'd0;
      r_enable <= '0;
      r_trig   <= '0;
    end else begin
      r_dphase <= w_capture;
      if (w_capture) begin
        r_daddr  <= haddr_i[4:2];
        r_dwrite <= hwrite_i;
      end
      if (w_wr && (r_daddr == c_idx_enable)) begin
        r_enable <= hwdata_i[NSRC-1:0];
      end
      if (w_wr && (r_daddr == c_idx_trig)) begin
        r_trig <= hwdata_i[NSRC-1:0];
      end
    end
  end

  generate
    for (genvar g = 0; g < NSRC; g++) begin : g_src
      intc_src_cell u_cell (
        .clk        (hclk),
        .rst_n      (hresetn),
        .i_src      (irq_src_i[g]),
        .i_trig     (r_trig[g]),
        .i_claim    (w_claim_go && (w_cand == 5'(g + 1))),
        .i_complete (w_complete),
        .o_pend     (w_pend[g])
      );
    end
  endgenerate

  assign w_act = w_pend & r_enable;
  assign w_any = |w_act;

  // Lowest source ID wins.
  always_comb begin
    w_cand = ID_NONE;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_cand = 5'(i + 1);
      end
    end
  end

  assign w_claim_go = w_rd & w_claim_sel & (r_state == ST_ACTIVE) & (w_cand != ID_NONE);
  assign w_complete = w_wr & w_claim_sel & (r_state == ST_CLAIMED) &
                      (hwdata_i == DWIDTH'(r_id));

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_claim_go) begin
          w_state_nxt = ST_CLAIMED;
          w_id_nxt    = w_cand;
        end else if (!w_any) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLAIMED: begin
        if (w_complete) begin
          w_state_nxt = ST_IDLE;
          w_id_nxt    = ID_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_id_nxt    = ID_NONE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
      r_id    <= ID_NONE;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_irq   <= (w_state_nxt == ST_ACTIVE);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (r_daddr)
        c_idx_enable:  w_rdata[NSRC-1:0] = r_enable;
        c_idx_pending: w_rdata[NSRC-1:0] = w_pend;
        c_idx_trig:    w_rdata[NSRC-1:0] = r_trig;
        c_idx_claim: begin
          if (r_state != ST_IDLE) begin
            w_rdata[4:0] = w_cand;
          end
        end
        c_idx_status: begin
          w_rdata[4:0] = r_id;
          w_rdata[8]   = (r_state == ST_CLAIMED);
        end
        default: w_rdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_intc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ahb_intc : self-checking bench for ahb_intc against a behavioural model. |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_ahb_intc;

  localparam int NSRC = 8;
`ifdef AHB_INTC_SYNC_EN
  localparam int DLY      = 3;
  localparam int IRQ_EDGE = 4;
`else
  localparam int DLY      = 1;
  localparam int IRQ_EDGE = 2;
`endif

  localparam logic [4:0] A_EN  = 5'h00;
  localparam logic [4:0] A_PND = 5'h04;
  localparam logic [4:0] A_TRG = 5'h08;
  localparam logic [4:0] A_CLM = 5'h0C;
  localparam logic [4:0] A_STS = 5'h10;

  logic            hclk    = 1'b0;
  logic            hresetn = 1'b0;
  logic            hsel    = 1'b0;
  logic            hwrite  = 1'b0;
  logic            hready  = 1'b1;
  logic [2:0]      hsize   = 3'b010;
  logic [2:0]      hburst  = 3'b000;
  logic [1:0]      htrans  = 2'b00;
  logic [31:0]     hwdata  = 32'h0;
  logic [31:0]     haddr   = 32'h0;
  logic [NSRC-1:0] src     = '0;
  logic            hreadyout_o;
  logic            hresp_o;
  logic [31:0]     hrdata_o;
  logic            irq_o;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 hclk = ~hclk;

  ahb_intc #(.AWIDTH(32), .DWIDTH(32), .NSRC(NSRC)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel_i      (hsel),
    .hwrite_i    (hwrite),
    .hready_i    (hready),
    .hsize_i     (hsize),
    .hburst_i    (hburst),
    .htrans_i    (htrans),
    .hwdata_i    (hwdata),
    .haddr_i     (haddr),
    .hreadyout_o (hreadyout_o),
    .hresp_o     (hresp_o),
    .hrdata_o    (hrdata_o),
    .irq_src_i   (src),
    .irq_o       (irq_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NSRC-1:0] m_pend, m_en, m_trig;
  logic [NSRC-1:0] m_hist [0:3];
  bit              m_irq;
  int              m_svc;
  bit              m_dv, m_dw;
  int              m_didx;

  function automatic logic [NSRC-1:0] m_vis();
    logic [NSRC-1:0] v;
    v = m_pend;
    if (m_svc != 0 && !m_trig[m_svc-1]) v[m_svc-1] = 1'b0;
    return v;
  endfunction

  function automatic int m_cand();
    logic [NSRC-1:0] a;
    a = m_vis() & m_en;
    for (int i = 0; i < NSRC; i++) if (a[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!m_dv || m_dw) return 32'h0;
    case (m_didx)
      0: return 32'(m_en);
      1: return 32'(m_vis());
      2: return 32'(m_trig);
      3: return (m_irq || m_svc != 0) ? 32'(m_cand()) : 32'h0;
      4: return {23'd0, (m_svc != 0), 3'd0, 5'(m_svc)};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge hclk or negedge hresetn) begin : b_model
    logic [NSRC-1:0] act, lvl, prv;
    int  cand;
    bit  claim_go, complete;
    if (!hresetn) begin
      m_pend = '0; m_en = '0; m_trig = '0;
      for (int k = 0; k < 4; k++) m_hist[k] = '0;
      m_irq = 0; m_svc = 0; m_dv = 0; m_dw = 0; m_didx = 0;
    end else begin
      act      = m_vis() & m_en;
      cand     = m_cand();
      claim_go = m_dv && !m_dw && m_didx == 3 && m_irq && cand != 0;
      complete = m_dv && m_dw && m_didx == 3 && m_svc != 0 && hwdata == 32'(m_svc);
      lvl      = m_hist[DLY-1];
      prv      = m_hist[DLY];
      for (int i = 0; i < NSRC; i++) begin
        if (m_trig[i]) begin
          if (lvl[i] && !prv[i]) m_pend[i] = 1'b1;
          else if (claim_go && cand == i + 1) m_pend[i] = 1'b0;
        end else begin
          m_pend[i] = lvl[i];
        end
      end
      if (m_dv && m_dw && m_didx == 0) m_en   = hwdata[NSRC-1:0];
      if (m_dv && m_dw && m_didx == 2) m_trig = hwdata[NSRC-1:0];
      if (m_svc != 0) begin
        if (complete) m_svc = 0;
      end else if (m_irq) begin
        if (claim_go) begin
          m_svc = cand;
          m_irq = 0;
        end else if (act == 0) begin
          m_irq = 0;
        end
      end else if (act != 0) begin
        m_irq = 1;
      end
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = src;
      m_dv = hsel && hready && htrans[1];
      if (m_dv) begin
        m_dw   = hwrite;
        m_didx = int'(haddr[4:2]);
      end
    end
  end

  always @(posedge hclk) begin
    #1;
    if (chk_en) begin
      chk("irq_o", 32'(irq_o), 32'(m_irq));
      chk("hrdata_o", hrdata_o, m_rdata());
      chk("hready_hresp", {30'd0, hreadyout_o, hresp_o}, 32'h2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_idle();
    hsel   = 1'b0;
    hwrite = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    hsel = 1'b1; hwrite = 1'b1; htrans = 2'b10; haddr = 32'(a);
    @(negedge hclk);
    hwdata = d;
    bus_idle();
    @(negedge hclk);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    hsel = 1'b1; hwrite = 1'b0; htrans = 2'b10; haddr = 32'(a);
    @(negedge hclk);
    d = hrdata_o;
    bus_idle();
    @(negedge hclk);
  endtask

  task automatic read_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(nm, d, exp);
  endtask

  task automatic pulse(input logic [NSRC-1:0] b);
    src = src | b;
    @(negedge hclk);
    src = src & ~b;
  endtask

  task automatic wait_irq(input string nm);
    int n;
    n = 0;
    while (!irq_o && n < 30) begin
      @(negedge hclk);
      n++;
    end
    chk(nm, 32'(irq_o), 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0]     rd;
  logic [NSRC-1:0] flip;
  int              cnt;

  initial begin
    repeat (3) @(negedge hclk);
    hresetn = 1'b1;
    chk_en  = 1'b1;
    chk("rst_irq", 32'(irq_o), 32'h0);
    read_chk("rst_enable", A_EN, 32'h0);
    read_chk("rst_pending", A_PND, 32'h0);
    read_chk("rst_trig", A_TRG, 32'h0);
    read_chk("rst_status", A_STS, 32'h0);
    read_chk("rst_claim", A_CLM, 32'h0);

    // Edge source: latency, claim, complete
    bus_write(A_EN, 32'h1);
    bus_write(A_TRG, 32'h1);
    cnt = 0;
    src[0] = 1'b1;
    do begin
      @(negedge hclk);
      cnt++;
      if (cnt == 1) src[0] = 1'b0;
    end while (!irq_o && cnt < 20);
    chk("edge_latency", 32'(cnt), 32'(IRQ_EDGE + 1));
    read_chk("edge_claim", A_CLM, 32'h1);
    chk("edge_irq_low", 32'(irq_o), 32'h0);
    read_chk("edge_pending", A_PND, 32'h0);
    read_chk("edge_status_busy", A_STS, 32'h101);
    bus_write(A_CLM, 32'h1);
    read_chk("edge_status_done", A_STS, 32'h0);

    // Priority and wrong complete
    bus_write(A_EN, 32'hFF);
    bus_write(A_TRG, 32'hFF);
    pulse(8'h24);
    wait_irq("prio_irq");
    read_chk("prio_claim3", A_CLM, 32'h3);
    bus_write(A_CLM, 32'h4);
    read_chk("wrong_complete", A_STS, 32'h103);
    bus_write(A_CLM, 32'h3);
    wait_irq("prio_reassert");
    read_chk("prio_claim6", A_CLM, 32'h6);
    bus_write(A_CLM, 32'h6);
    repeat (3) @(negedge hclk);
    chk("prio_idle", 32'(irq_o), 32'h0);

    // Edge arriving on the claim edge stays pending
    pulse(8'h04);
    wait_irq("setclr_irq");
    src[2] = 1'b1;
    repeat (DLY - 1) @(negedge hclk);
    read_chk("setclr_claim", A_CLM, 32'h3);
    src[2] = 1'b0;
    read_chk("setclr_pending", A_PND, 32'h4);
    chk("setclr_irq_low", 32'(irq_o), 32'h0);
    bus_write(A_CLM, 32'h3);
    wait_irq("setclr_reassert");
    read_chk("setclr_claim_again", A_CLM, 32'h3);
    bus_write(A_CLM, 32'h3);

    // Level source
    bus_write(A_TRG, 32'h0);
    src[1] = 1'b1;
    wait_irq("level_irq");
    read_chk("level_claim", A_CLM, 32'h2);
    read_chk("level_masked", A_PND, 32'h0);
    bus_write(A_CLM, 32'h2);
    wait_irq("level_reassert");
    read_chk("level_pending", A_PND, 32'h2);
    src[1] = 1'b0;
    repeat (DLY + 2) @(negedge hclk);
    read_chk("level_dropped", A_PND, 32'h0);
    chk("level_irq_low", 32'(irq_o), 32'h0);

    // Masking by ENABLE
    bus_write(A_EN, 32'h0);
    bus_write(A_TRG, 32'hFF);
    pulse(8'h01);
    repeat (DLY + 3) @(negedge hclk);
    chk("mask_irq_low", 32'(irq_o), 32'h0);
    read_chk("mask_claim0", A_CLM, 32'h0);
    read_chk("mask_pending", A_PND, 32'h1);
    bus_write(A_EN, 32'h1);
    chk("mask_irq_cycle1", 32'(irq_o), 32'h0);
    @(negedge hclk);
    chk("mask_irq_cycle2", 32'(irq_o), 32'h1);
    read_chk("mask_claim1", A_CLM, 32'h1);

    // Reset while a source is in service
    hresetn = 1'b0;
    @(negedge hclk);
    chk("midrst_irq", 32'(irq_o), 32'h0);
    hresetn = 1'b1;
    read_chk("midrst_status", A_STS, 32'h0);
    read_chk("midrst_pending", A_PND, 32'h0);
    read_chk("midrst_enable", A_EN, 32'h0);
    read_chk("midrst_trig", A_TRG, 32'h0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int it = 0; it < 700; it++) begin
      flip = NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom);
      src  = src ^ flip;
      case ($urandom_range(0, 6))
        0: @(negedge hclk);
        1: bus_read(A_CLM, rd);
        2: bus_read(5'({3'($urandom_range(0, 7)), 2'b00}), rd);
        3: bus_write(A_EN, $urandom);
        4: bus_write(A_TRG, $urandom);
        5: bus_write(A_CLM, (m_svc != 0) ? 32'(m_svc) : 32'($urandom_range(0, 9)));
        default: bus_write(A_CLM, 32'($urandom_range(0, 9)));
      endcase
    end

    src = '0;
    repeat (4) @(negedge hclk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
